fetch_npc_btb: RTL
==================

# fetch_npc_btb

Next-PC generation stage for the pipelined miniRV core, sitting in IF directly upstream of the 2-bit branch predictor's consumer path. It holds the PC register and a direct-mapped branch target buffer (BTB). It combines a BTB hit with the predictor's `pre_br` bit to choose the fetch address. It also resolves mispredictions reported from EX into a redirect plus flush, and maintains branch and mispredict statistics counters.

## Interface
- `BTB_ENTRIES`, 16, number of BTB entries; power of two, ≥2; `IDX = log2(BTB_ENTRIES)`.
- `PC_RESET`, 32'h0000_0000, PC value loaded on reset.

- `cpu_clk`  in  1  clock, rising edge.
- `cpu_rst`  in  1  reset, asynchronous, active-high.
- `stall`  in  1  hazard-unit hold; PC keeps its value.
- `pre_br`  in  1  predictor direction bit (1 = taken).
- `pc`  out  32  current fetch PC (register).
- `pred_taken`  out  1  prediction used for the current fetch; travels down the pipe to EX.
- `pred_target`  out  32  predicted target for the current fetch; travels down the pipe to EX.
- `ex_is_B`  in  1  EX holds a valid B-type instruction; drives the predictor's `is_B`.
- `ex_pc`  in  32  PC of the EX instruction.
- `ex_real_br`  in  1  resolved direction.
- `ex_target`  in  32  resolved taken target (`ex_pc` + imm).
- `ex_pred_taken`  in  1  `pred_taken` carried to EX.
- `ex_pred_target`  in  32  `pred_target` carried to EX.
- `flush`  out  1  kill the IF/ID and ID/EX instructions this cycle.
- `br_cnt`  out  32  resolved B-type count.
- `mis_cnt`  out  32  mispredict count.

## Operation
- BTB entry fields: `valid`, `tag = pc[31:2+IDX]`, `target[31:0]`. Index = `pc[IDX+1:2]`.
- Lookup is combinational on `pc`.
  - `hit = valid[idx] && tag[idx] == pc[31:2+IDX]`.
  - `pred_taken = hit && pre_br`.
  - `pred_target = pred_taken ? target[idx] : pc + 4`.
- Mispredict is combinational: `mis = ex_is_B && (ex_real_br != ex_pred_taken || (ex_real_br && ex_target != ex_pred_target))`.
  - `flush = mis`.
  - `redirect = ex_real_br ? ex_target : ex_pc + 4`.
- Next-PC priority, highest first:
  1. reset → `PC_RESET`
  2. `mis` → `redirect`; this overrides `stall`.
  3. `stall` → hold `pc`.
  4. otherwise → `pred_target`.
- BTB update, at the clock edge:
  - When `ex_is_B && ex_real_br`, write `valid=1`, tag and target from `ex_pc` / `ex_target` into the entry at `ex_pc`'s index. A tag conflict overwrites the old entry.
  - Not-taken branches never allocate and never invalidate.
  - BTB writes occur regardless of `stall`.
- Counters, at the clock edge:
  - `br_cnt` += 1 when `ex_is_B`.
  - `mis_cnt` += 1 when `mis`.
  - Both are 32-bit and wrap modulo 2^32.
- PC arithmetic is 32-bit and wraps; `32'hFFFF_FFFC + 4 = 0`.
- `ex_is_B = 0` suppresses `mis`, `flush`, BTB writes and counter increments, whatever the other `ex_*` inputs are.

## Timing
- Reset values:
  - `pc = PC_RESET`.
  - All `valid = 0`; tag and target are don't-care.
  - `br_cnt = mis_cnt = 0`.
  - Outputs immediately after reset: `pred_taken = 0`, `pred_target = PC_RESET + 4`.
  - `flush` follows the EX inputs combinationally.
- Reset is asynchronous; asserting it mid-operation forces the reset values immediately and suppresses any write pending on that edge.
- `pred_taken` and `pred_target` are valid in the same cycle as `pc`, with zero-cycle latency from `pc`/`pre_br`.
- Flush and redirect:
  - `flush` is asserted in the same cycle as the EX resolution and lasts exactly one cycle per mispredicting branch.
  - The redirected `pc` appears after the next rising edge.
- BTB write vs. lookup on the same index in the same cycle: the lookup sees the old contents; the new entry is visible from the following cycle. No bypass.
- Predictor contract:
  - `ex_is_B` and `ex_real_br` feed the predictor in the same cycle.
  - `pre_br` reflects the predictor's state before that cycle's update edge.

## Test plan
- Reset with `PC_RESET=0`, `stall=0`, no branches → after 3 edges `pc = 0x0C`; `pred_taken = 0`; `flush = 0`; counters stay 0.
- Cold taken branch at `ex_pc=0x40`, `ex_target=0x100`, `ex_pred_taken=0` → `flush=1` for one cycle; next `pc = 0x100`; `br_cnt=1`, `mis_cnt=1`. Later, with `pc=0x40` and `pre_br=1` → `pred_taken=1`, `pred_target=0x100`.
- Same branch resolves not-taken with `ex_pred_taken=1` → `flush=1`; next `pc = 0x44`; `mis_cnt` increments; the BTB entry stays valid.
- `stall=1` together with a mispredict → redirect wins, next `pc = redirect`. `stall=1` without a mispredict → `pc` holds for every stalled cycle.
- Aliasing with `BTB_ENTRIES=16`: taken branches at 0x40 → 0x200, then at 0x80 → 0x300 (same index). Afterwards `pc=0x40` gives `pred_taken=0` (tag miss) and `pc=0x80` with `pre_br=1` gives `pred_target=0x300`.
- Correct prediction (`ex_pred_taken=1`, `ex_real_br=1`, targets equal) → `flush=0`; `br_cnt` increments, `mis_cnt` unchanged. Assert `cpu_rst` mid-sequence → `pc`, counters and all valid bits clear immediately.

Source files
------------

// File: rtl/fetch_npc_btb.sv
// fetch_npc_btb: IF-stage next-PC generation for the pipelined miniRV core.
// Holds the fetch PC and a direct-mapped branch target buffer. A BTB hit
// combined with the predictor's direction bit steers the fetch address.
// Mispredictions resolved in EX redirect the PC and flush the younger
// instructions. Branch and mispredict statistics counters are maintained.
module fetch_npc_btb #(
    parameter int          BTB_ENTRIES = 16,
    parameter logic [31:0] PC_RESET    = 32'h0000_0000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        stall,
    input  logic        pre_br,
    output logic [31:0] pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_is_B,
    input  logic [31:0] ex_pc,
    input  logic        ex_real_br,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        flush,
    output logic [31:0] br_cnt,
    output logic [31:0] mis_cnt
);

    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = 30 - IDX;

    // BTB storage: valid bits are reset, tag/target payload is not
    logic [BTB_ENTRIES-1:0] r_valid;
    logic [TAGW-1:0]        r_tag    [BTB_ENTRIES];
    logic [31:0]            r_target [BTB_ENTRIES];

    logic [31:0] r_pc;
    logic [31:0] r_br_cnt;
    logic [31:0] r_mis_cnt;

    logic [IDX-1:0]  w_idx;
    logic [TAGW-1:0] w_tag;
    logic            w_hit;
    logic            w_pred_taken;
    logic [31:0]     w_pred_target;
    logic            w_mis;
    logic [31:0]     w_redirect;
    logic [31:0]     w_npc;
    logic            w_btb_wr;
    logic [IDX-1:0]  w_wr_idx;
    logic [TAGW-1:0] w_wr_tag;

    assign w_idx    = r_pc[IDX+1:2];
    assign w_tag    = r_pc[31:2+IDX];
    assign w_wr_idx = ex_pc[IDX+1:2];
    assign w_wr_tag = ex_pc[31:2+IDX];
    assign w_btb_wr = ex_is_B && ex_real_br;

    // BTB lookup on the current PC; sees pre-edge contents, no write bypass
    always_comb begin
        w_hit         = 1'b0;
        w_pred_taken  = 1'b0;
        w_pred_target = r_pc + 32'd4;
        if (r_valid[w_idx] && (r_tag[w_idx] == w_tag)) begin
            w_hit = 1'b1;
        end else begin
            w_hit = 1'b0;
        end
        w_pred_taken = w_hit && pre_br;
        if (w_pred_taken) begin
            w_pred_target = r_target[w_idx];
        end else begin
            w_pred_target = r_pc + 32'd4;
        end
    end

    // EX-stage mispredict detection and the corrected fetch address
    always_comb begin
        w_mis      = 1'b0;
        w_redirect = ex_pc + 32'd4;
        if (ex_is_B) begin
            w_mis = (ex_real_br != ex_pred_taken) ||
                    (ex_real_br && (ex_target != ex_pred_target));
        end else begin
            w_mis = 1'b0;
        end
        if (ex_real_br) begin
            w_redirect = ex_target;
        end else begin
            w_redirect = ex_pc + 32'd4;
        end
    end

    // Next-PC select: a mispredict redirect overrides a stall
    always_comb begin
        w_npc = w_pred_target;
        if (w_mis) begin
            w_npc = w_redirect;
        end else if (stall) begin
            w_npc = r_pc;
        end else begin
            w_npc = w_pred_target;
        end
    end

    // PC register
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_pc <= PC_RESET;
        end else begin
            r_pc <= w_npc;
        end
    end

    // BTB valid bits: taken branches allocate, nothing ever invalidates
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_valid <= '0;
        end else if (w_btb_wr) begin
            r_valid[w_wr_idx] <= 1'b1;
        end else begin
            r_valid <= r_valid;
        end
    end

    // BTB tag/target payload, overwritten on every taken branch
    always_ff @(posedge cpu_clk) begin
        if (w_btb_wr && !cpu_rst) begin
            r_tag[w_wr_idx]    <= w_wr_tag;
            r_target[w_wr_idx] <= ex_target;
        end
    end

    // Statistics counters, wrapping modulo 2^32
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_br_cnt  <= 32'd0;
            r_mis_cnt <= 32'd0;
        end else begin
            if (ex_is_B) begin
                r_br_cnt <= r_br_cnt + 32'd1;
            end else begin
                r_br_cnt <= r_br_cnt;
            end
            if (w_mis) begin
                r_mis_cnt <= r_mis_cnt + 32'd1;
            end else begin
                r_mis_cnt <= r_mis_cnt;
            end
        end
    end

    assign pc          = r_pc;
    assign pred_taken  = w_pred_taken;
    assign pred_target = w_pred_target;
    assign flush       = w_mis;
    assign br_cnt      = r_br_cnt;
    assign mis_cnt     = r_mis_cnt;

endmodule
